// File: rtl/dp_mem_ctrl.sv
// Dual-port memory controller: host port A with range checking, arbitrated client port B,
// hardware collision resolution and write-first forwarding. Optional parity: MEMCTRL_PARITY_EN.
module dp_mem_ctrl #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 15,
   parameter int DEPTH      = 32768,
   parameter int EXT_ADDR_W = 24
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [EXT_ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0]     a_wdata,
   output logic                  a_rvalid,
   output logic [DATA_W-1:0]     a_rdata,
   output logic                  a_err,
   input  logic                  b_wr_req,
   input  logic [ADDR_W-1:0]     b_wr_addr,
   input  logic [DATA_W-1:0]     b_wdata,
   output logic                  b_wr_ready,
   input  logic                  b_rd_req,
   input  logic [ADDR_W-1:0]     b_rd_addr,
   output logic                  b_rd_ready,
   output logic                  b_rvalid,
   output logic [DATA_W-1:0]     b_rdata
`ifdef MEMCTRL_PARITY_EN
   ,
   output logic                  a_perr,
   output logic                  b_perr
`endif
);

   localparam int NP = 2;
`ifdef MEMCTRL_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif
   localparam logic [EXT_ADDR_W:0] DEPTH_EXT = (EXT_ADDR_W+1)'(DEPTH);

   function automatic logic [MEM_W-1:0] encodeWord(input logic [DATA_W-1:0] d);
`ifdef MEMCTRL_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   logic [MEM_W-1:0] mem [0:DEPTH-1];
   logic [MEM_W-1:0] ramQ [NP];

   // Port A decode: any address bit above the RAM range makes the access out of range
   logic [ADDR_W-1:0] aIdx;
   logic              aInRange, aWrEn, aRdAcc, aErrAcc;

   assign aIdx     = a_addr[ADDR_W-1:0];
   assign aInRange = ({1'b0, a_addr} < DEPTH_EXT);
   assign aWrEn    = RST_N & a_req & a_we & aInRange;
   assign aRdAcc   = RST_N & a_req & ~a_we;
   assign aErrAcc  = RST_N & a_req & ~aInRange;

   // Port B arbitration; a colliding B write yields to port A and lets a pending read through
   logic              prefRdReg;
   logic              collide, contested, bWrGrant, bRdGrant;
   logic [ADDR_W-1:0] bAddr;

   always_comb begin
      collide   = aWrEn & b_wr_req & (aIdx == b_wr_addr);
      contested = 1'b0;
      bWrGrant  = 1'b0;
      bRdGrant  = 1'b0;
      if (RST_N) begin
         if (collide) begin
            bRdGrant = b_rd_req;
         end else if (b_wr_req & b_rd_req) begin
            contested = 1'b1;
            bWrGrant  = ~prefRdReg;
            bRdGrant  = prefRdReg;
         end else begin
            bWrGrant = b_wr_req;
            bRdGrant = b_rd_req;
         end
      end
   end

   assign b_wr_ready = bWrGrant;
   assign b_rd_ready = bRdGrant;
   assign bAddr      = bWrGrant ? b_wr_addr : b_rd_addr;

   always_ff @(posedge CLK) begin
      if (!RST_N)
         prefRdReg <= 1'b0;
      else if (contested)
         prefRdReg <= ~prefRdReg;
   end

   // Collision logic guarantees the two write ports never target the same word in one cycle
   always_ff @(posedge CLK) begin
      if (aWrEn)
         mem[aIdx] <= encodeWord(a_wdata);
      if (bWrGrant)
         mem[bAddr] <= encodeWord(b_wdata);
      ramQ[0] <= mem[aIdx];
      ramQ[1] <= mem[bAddr];
   end

   // Per-port read request, range flag and cross-port forwarding capture
   logic [NP-1:0]     rdAcc, rdOor, fwdHit;
   logic [DATA_W-1:0] fwdDat [NP];

   always_comb begin
      rdAcc     = {bRdGrant, aRdAcc};
      rdOor     = {1'b0, ~aInRange};
      fwdHit[0] = aRdAcc & aInRange & bWrGrant & (b_wr_addr == aIdx);
      fwdHit[1] = bRdGrant & aWrEn & (aIdx == b_rd_addr);
      fwdDat[0] = b_wdata;
      fwdDat[1] = a_wdata;
   end

   logic [NP-1:0]     rvalidVec;
   logic [DATA_W-1:0] rdataArr [NP];
`ifdef MEMCTRL_PARITY_EN
   logic [NP-1:0]     perrVec;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NP; gi++) begin : g_port
         logic              pendReg, oorReg, fwdReg, rvalidReg;
         logic [DATA_W-1:0] fwdDataReg, rdataReg, rdWord;

         always_comb begin
            rdWord = ramQ[gi][DATA_W-1:0];
            if (oorReg)
               rdWord = '0;
            else if (fwdReg)
               rdWord = fwdDataReg;
         end

         always_ff @(posedge CLK) begin
            if (!RST_N) begin
               pendReg    <= 1'b0;
               oorReg     <= 1'b0;
               fwdReg     <= 1'b0;
               fwdDataReg <= '0;
               rvalidReg  <= 1'b0;
               rdataReg   <= '0;
            end else begin
               pendReg    <= rdAcc[gi];
               oorReg     <= rdOor[gi];
               fwdReg     <= fwdHit[gi];
               fwdDataReg <= fwdDat[gi];
               rvalidReg  <= pendReg;
               if (pendReg)
                  rdataReg <= rdWord;
            end
         end

         assign rvalidVec[gi] = rvalidReg;
         assign rdataArr[gi]  = rdataReg;

`ifdef MEMCTRL_PARITY_EN
         // Forwarded and out-of-range words never come from storage, so they cannot fail parity
         logic perrReg;
         always_ff @(posedge CLK) begin
            if (!RST_N)
               perrReg <= 1'b0;
            else
               perrReg <= pendReg & ~oorReg & ~fwdReg &
                          (ramQ[gi][DATA_W] != ^ramQ[gi][DATA_W-1:0]);
         end
         assign perrVec[gi] = perrReg;
`endif
      end
   endgenerate

   // Out-of-range reports follow the same two-stage timing as read data
   logic errPendReg, errReg;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         errPendReg <= 1'b0;
         errReg     <= 1'b0;
      end else begin
         errPendReg <= aErrAcc;
         errReg     <= errPendReg;
      end
   end

   assign a_rvalid = rvalidVec[0];
   assign a_rdata  = rdataArr[0];
   assign a_err    = errReg;
   assign b_rvalid = rvalidVec[1];
   assign b_rdata  = rdataArr[1];
`ifdef MEMCTRL_PARITY_EN
   assign a_perr   = perrVec[0];
   assign b_perr   = perrVec[1];
`endif

endmodule

// File: tb/tb_dp_mem_ctrl.sv
// Scoreboard bench for dp_mem_ctrl: a word-array reference model with write-first reads predicts
// grants and read responses; a negedge monitor pops and compares whatever the DUT presents.
module tb_dp_mem_ctrl;
   localparam int DATA_W = 16, ADDR_W = 15, DEPTH = 32768, EXT_ADDR_W = 24;

   logic                  CLK = 1'b0, RST_N = 1'b0;
   logic                  a_req = 1'b0, a_we = 1'b0;
   logic [EXT_ADDR_W-1:0] a_addr = '0;
   logic [DATA_W-1:0]     a_wdata = '0;
   logic                  a_rvalid, a_err;
   logic [DATA_W-1:0]     a_rdata;
   logic                  b_wr_req = 1'b0, b_rd_req = 1'b0;
   logic [ADDR_W-1:0]     b_wr_addr = '0, b_rd_addr = '0;
   logic [DATA_W-1:0]     b_wdata = '0;
   logic                  b_wr_ready, b_rd_ready, b_rvalid;
   logic [DATA_W-1:0]     b_rdata;
`ifdef MEMCTRL_PARITY_EN
   logic                  a_perr, b_perr;
`endif

   dp_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .EXT_ADDR_W(EXT_ADDR_W)) dut (
`ifdef MEMCTRL_PARITY_EN
      .a_perr(a_perr), .b_perr(b_perr),
`endif
      .CLK(CLK), .RST_N(RST_N),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
      .b_wr_req(b_wr_req), .b_wr_addr(b_wr_addr), .b_wdata(b_wdata), .b_wr_ready(b_wr_ready),
      .b_rd_req(b_rd_req), .b_rd_addr(b_rd_addr), .b_rd_ready(b_rd_ready),
      .b_rvalid(b_rvalid), .b_rdata(b_rdata)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int checks = 0, passes = 0;

   typedef struct {
      int          due;
      bit          rv;
      bit          err;
      logic [15:0] data;
   } expT;

   expT         aQ[$], bQ[$];
   expT         monE;
   logic [15:0] mdl [DEPTH];
   bit          mdlPrefRd = 1'b0;
   logic [23:0] pool [11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp)
         $display("FAIL %s @cycle %0d: got 0x%0h, required 0x%0h", nm, cyc, act, exp);
      else
         passes++;
   endtask

   // One bus cycle: drive inputs, predict grants from the model, push expected responses.
   task automatic step(input bit rstn, input bit aReq, input bit aWe, input logic [23:0] aAddr,
                       input logic [15:0] aWd, input bit bWr, input logic [14:0] bWa,
                       input logic [15:0] bWd, input bit bRd, input logic [14:0] bRa,
                       input bit zeroChk, output bit gW, output bit gR);
      bit  aInR, aW, collide;
      int  t;
      expT e;
      @(posedge CLK);
      #1;
      t = cyc;
      if (zeroChk) begin
         chk("rst_a_rvalid", a_rvalid, 0);
         chk("rst_a_err", a_err, 0);
         chk("rst_a_rdata", a_rdata, 0);
         chk("rst_b_rvalid", b_rvalid, 0);
         chk("rst_b_rdata", b_rdata, 0);
      end
      RST_N = rstn; a_req = aReq; a_we = aWe; a_addr = aAddr; a_wdata = aWd;
      b_wr_req = bWr; b_wr_addr = bWa; b_wdata = bWd; b_rd_req = bRd; b_rd_addr = bRa;
      #1;
      aInR    = (aAddr < DEPTH);
      aW      = rstn && aReq && aWe && aInR;
      collide = aW && bWr && (aAddr[14:0] == bWa);
      gW = 1'b0;
      gR = 1'b0;
      if (!rstn) begin
         mdlPrefRd = 1'b0;
      end else if (collide) begin
         gR = bRd;
      end else if (bWr && bRd) begin
         gW = !mdlPrefRd;
         gR = mdlPrefRd;
         mdlPrefRd = !mdlPrefRd;
      end else begin
         gW = bWr;
         gR = bRd;
      end
      chk("b_wr_ready", b_wr_ready, gW);
      chk("b_rd_ready", b_rd_ready, gR);
      // Reads accepted this cycle observe this cycle's writes.
      if (aW) mdl[aAddr[14:0]] = aWd;
      if (gW) mdl[bWa] = bWd;
      if (rstn && aReq && (!aWe || !aInR)) begin
         e.due = t + 2; e.rv = !aWe; e.err = !aInR;
         e.data = (!aWe && aInR) ? mdl[aAddr[14:0]] : 16'h0000;
         aQ.push_back(e);
      end
      if (gR) begin
         e.due = t + 2; e.rv = 1'b1; e.err = 1'b0; e.data = mdl[bRa];
         bQ.push_back(e);
      end
      if (!rstn) begin
         for (int i = aQ.size() - 1; i >= 0; i--) if (aQ[i].due >= t + 1) aQ.delete(i);
         for (int i = bQ.size() - 1; i >= 0; i--) if (bQ[i].due >= t + 1) bQ.delete(i);
      end
   endtask

   task automatic aOp(input bit we, input logic [23:0] ad, input logic [15:0] d);
      bit w, r;
      step(1, 1, we, ad, d, 0, '0, '0, 0, '0, 0, w, r);
   endtask

   task automatic idle(input bit rstn, input bit zc);
      bit w, r;
      step(rstn, 0, 0, '0, '0, 0, '0, '0, 0, '0, zc, w, r);
   endtask

   // Monitor: compares every DUT response against the head of its port queue.
   always @(negedge CLK) begin
      while (aQ.size() > 0 && aQ[0].due < cyc) begin
         checks++;
         $display("FAIL a_missing @cycle %0d: no response, required one at cycle %0d", cyc, aQ[0].due);
         void'(aQ.pop_front());
      end
      if (a_rvalid || a_err) begin
         if (aQ.size() == 0 || aQ[0].due != cyc) begin
            checks++;
            $display("FAIL a_unexpected @cycle %0d: got rvalid=%0b err=%0b, required none", cyc, a_rvalid, a_err);
         end else begin
            monE = aQ.pop_front();
            chk("a_rvalid", a_rvalid, monE.rv);
            chk("a_err", a_err, monE.err);
            if (monE.rv) chk("a_rdata", a_rdata, monE.data);
         end
      end
      while (bQ.size() > 0 && bQ[0].due < cyc) begin
         checks++;
         $display("FAIL b_missing @cycle %0d: no response, required one at cycle %0d", cyc, bQ[0].due);
         void'(bQ.pop_front());
      end
      if (b_rvalid) begin
         if (bQ.size() == 0 || bQ[0].due != cyc) begin
            checks++;
            $display("FAIL b_unexpected @cycle %0d: got rvalid=1, required none", cyc);
         end else begin
            monE = bQ.pop_front();
            chk("b_rdata", b_rdata, monE.data);
         end
`ifdef MEMCTRL_PARITY_EN
         chk("b_perr", b_perr, 0);
`endif
      end
`ifdef MEMCTRL_PARITY_EN
      if (a_rvalid) chk("a_perr", a_perr, 0);
`endif
   end

   initial begin
      bit          gW, gR, pw, pr;
      logic [14:0] pwa, pra;
      logic [15:0] pwd;
      pool[0] = 24'h000000; pool[1] = 24'h007FFF; pool[2] = 24'h000010; pool[3] = 24'h000100;
      pool[4] = 24'h000200; pool[5] = 24'h000005; pool[6] = 24'h000007; pool[7] = 24'h000300;
      pool[8] = 24'h008000; pool[9] = 24'h010005; pool[10] = 24'hFFFFFF;

      repeat (3) idle(0, 0);
      idle(1, 1);
      for (int i = 0; i < 8; i++) aOp(1, pool[i], 16'($urandom));

      // Basic write/read, then range handling and boundary addresses
      aOp(1, 24'h000010, 16'h1234);
      aOp(0, 24'h000010, '0);
      aOp(0, 24'h008000, '0);
      aOp(1, 24'h010005, 16'hBEEF);
      aOp(0, 24'h000005, '0);
      aOp(0, 24'h007FFF, '0);
      aOp(0, 24'h000000, '0);

      // Contested port B: both requests held for four cycles
      for (int i = 0; i < 4; i++)
         step(1, 0, 0, '0, '0, 1, 15'h0007, 16'(16'h7000 + i), 1, 15'h0005, 0, gW, gR);

      // Cross-port collision with a simultaneous B read, then the held B write commits
      step(1, 1, 1, 24'h000100, 16'hAAAA, 1, 15'h0100, 16'h5555, 1, 15'h0100, 0, gW, gR);
      step(1, 0, 0, '0, '0, 1, 15'h0100, 16'h5555, 0, '0, 0, gW, gR);
      step(1, 0, 0, '0, '0, 0, '0, '0, 1, 15'h0100, 0, gW, gR);

      // Reset one cycle after a B read: the read is dropped, requests during reset ignored
      step(1, 0, 0, '0, '0, 0, '0, '0, 1, 15'h0200, 0, gW, gR);
      step(0, 1, 1, 24'h000200, 16'hDEAD, 1, 15'h0200, 16'hDEAD, 1, 15'h0200, 0, gW, gR);
      idle(1, 1);
      aOp(0, 24'h000200, '0);

      // Randomized traffic over a small shared address pool to provoke collisions
      pw = 0; pr = 0; pwa = '0; pra = '0; pwd = '0;
      for (int i = 0; i < 600; i++) begin
         bit          rq, we, rs;
         logic [23:0] ad;
         if (!pw && $urandom_range(0, 1) == 1) begin
            pw = 1; pwa = pool[$urandom_range(0, 7)][14:0]; pwd = 16'($urandom);
         end
         if (!pr && $urandom_range(0, 1) == 1) begin
            pr = 1; pra = pool[$urandom_range(0, 7)][14:0];
         end
         rq = ($urandom_range(0, 9) < 7);
         we = ($urandom_range(0, 1) == 1);
         ad = pool[$urandom_range(0, 10)];
         rs = ($urandom_range(0, 99) != 0);
         step(rs, rq, we, ad, 16'($urandom), pw, pwa, pwd, pr, pra, 0, gW, gR);
         if (gW) pw = 0;
         if (gR) pr = 0;
      end

      repeat (4) idle(1, 0);
      @(negedge CLK);
      #1;
      chk("a_queue_drained", aQ.size(), 0);
      chk("b_queue_drained", bQ.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
